// File: rtl/io_handshake_accumulator.sv
// Takes 16-bit words from a host over a 4-phase req/ack handshake and accumulates a sum and a word count.
// One word per req high phase; status and accumulators are shown on a sel-muxed 8-bit display bus.
module io_handshake_accumulator #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] io_in,
  output logic [27:0] io_out,
  output logic [27:0] io_oeb
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2,
    ERR     = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [15:0]            sum_q, sum_d;
  logic [7:0]             count_q, count_d;
  logic                   err_q, err_d;
  logic                   carry_q, carry_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;

  logic        req_sync;
  logic [16:0] add_res;
  logic [1:0]  sel;
  logic [7:0]  disp;
  logic        ack;
  logic        unused_in;

  // Only req crosses into the clock domain; the host holds data stable until it sees ack.
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], io_in[16]};
  assign req_sync = sync_q[SYNC_STAGES-1];
  assign add_res  = {1'b0, sum_q} + {1'b0, io_in[15:0]};

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    count_d = count_q;
    err_d   = err_q;
    carry_d = carry_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      IDLE: begin
        if (req_sync) state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = ACK;
        sum_d   = add_res[15:0];
        count_d = count_q + 8'd1;
        carry_d = carry_q | add_res[16];
        tcnt_d  = '0;
      end
      ACK: begin
        // A falling req takes priority over a timeout on the same edge.
        if (!req_sync) begin
          state_d = IDLE;
        end else if (tcnt_q == TLAST) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ERR: begin
        if (!req_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      sum_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      carry_q <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      err_q   <= err_d;
      carry_q <= carry_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign sel = io_in[19:18];
  assign ack = (state_q == ACK);

  always_comb begin
    disp = sum_q[7:0];
    case (sel)
      2'b00: disp = sum_q[7:0];
      2'b01: disp = sum_q[15:8];
      2'b10: disp = count_q;
      2'b11: disp = {err_q, carry_q, 4'b0000, state_q};
      default: disp = sum_q[7:0];
    endcase
  end

  assign io_out    = {disp, 2'b00, ack, 17'd0};
  assign io_oeb    = 28'h00DFFFF;
  assign unused_in = ^{io_in[27:20], io_in[17]};

endmodule

// File: tb/tb_io_handshake_accumulator.sv
// Scoreboard bench: the driver queues the expected accumulator state per word, a monitor checks it on each ack rise.
`timescale 1ns/1ps
module tb_io_handshake_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [27:0] io_in;
  logic [27:0] io_out;
  logic [27:0] io_oeb;
  logic [15:0] data;
  logic        req;
  logic [1:0]  sel;

  typedef struct {
    logic [15:0] sum;
    logic [7:0]  cnt;
    logic [7:0]  st;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  assign io_in = {8'h00, sel, 1'b0, req, data};

  io_handshake_accumulator #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic chk_disp(input string name, input logic [1:0] s, input logic [7:0] expv);
    sel = s;
    #1;
    chk(name, {24'd0, io_out[27:20]}, {24'd0, expv});
  endtask

  // Monitor: on each ack rise, pop the expected state and read all four display views.
  logic ack_prev = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    if (io_out[17] && !ack_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected_ack: ack rose with empty scoreboard");
      end else begin
        e = sb_q.pop_front();
        sel = 2'b00; #1; chk("mon_sum_lo", {24'd0, io_out[27:20]}, {24'd0, e.sum[7:0]});
        sel = 2'b01; #1; chk("mon_sum_hi", {24'd0, io_out[27:20]}, {24'd0, e.sum[15:8]});
        sel = 2'b10; #1; chk("mon_count",  {24'd0, io_out[27:20]}, {24'd0, e.cnt});
        sel = 2'b11; #1; chk("mon_status", {24'd0, io_out[27:20]}, {24'd0, e.st});
        sel = 2'b00;
      end
    end
    ack_prev = io_out[17];
  end

  always @(negedge clk) begin
    chk("io_oeb", {4'd0, io_oeb}, 32'h00DFFFF);
    chk("io_out_mask", {4'd0, io_out & ~28'hFF20000}, 32'd0);
  end

  task automatic wait_ack(input logic level, output int n);
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      n++;
      if (io_out[17] == level) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_ack: ack never reached %0b within 60 cycles", level);
    n = -1;
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] es, input logic [7:0] ec,
                      input logic [7:0] est);
    int n;
    exp_t x;
    x.sum = es; x.cnt = ec; x.st = est;
    sb_q.push_back(x);
    data = d;
    req  = 1'b1;
    wait_ack(1'b1, n);
    chk("ack_rise_latency", n, 4);
    req = 1'b0;
    wait_ack(1'b0, n);
    chk("ack_fall_latency", n, 3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 1'b0;
    data = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t x;
    rst = 1'b1; req = 1'b0; data = 16'h0; sel = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'd0, io_out[17]}, 32'd0);
    chk_disp("rst_sum_lo", 2'b00, 8'h00);
    chk_disp("rst_status", 2'b11, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // T1: single word, latency and display views.
    send(16'h1234, 16'h1234, 8'h01, 8'h02);
    chk_disp("t1_sum_lo", 2'b00, 8'h34);
    chk_disp("t1_sum_hi", 2'b01, 8'h12);
    chk_disp("t1_count",  2'b10, 8'h01);

    // T2: overflow sets sticky carry.
    do_reset();
    send(16'hFFFF, 16'hFFFF, 8'h01, 8'h02);
    send(16'h0002, 16'h0001, 8'h02, 8'h42);
    chk_disp("t2_sum_lo", 2'b00, 8'h01);
    chk_disp("t2_sum_hi", 2'b01, 8'h00);
    chk_disp("t2_count",  2'b10, 8'h02);
    chk_disp("t2_status", 2'b11, 8'h40);

    // T3: req held high past the 16-cycle timeout.
    do_reset();
    x.sum = 16'h0005; x.cnt = 8'h01; x.st = 8'h02;
    sb_q.push_back(x);
    data = 16'h0005;
    req  = 1'b1;
    wait_ack(1'b1, n);
    chk("t3_rise_latency", n, 4);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n++;
      if (!io_out[17]) break;
    end
    chk("t3_ack_cycles", n, 16);
    chk_disp("t3_status_err", 2'b11, 8'h83);
    repeat (3) @(negedge clk);
    chk_disp("t3_status_hold", 2'b11, 8'h83);
    chk_disp("t3_count_hold", 2'b10, 8'h01);
    req = 1'b0;
    repeat (4) @(negedge clk);
    chk_disp("t3_status_idle", 2'b11, 8'h80);
    send(16'h0003, 16'h0008, 8'h02, 8'h82);
    chk_disp("t3_count_after", 2'b10, 8'h02);
    chk_disp("t3_sum_after", 2'b00, 8'h08);

    // T4: 256 words wrap the count back to zero.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send(16'h0001, 16'(i + 1), 8'(i + 1), 8'h02);
    end
    chk_disp("t4_count", 2'b10, 8'h00);
    chk_disp("t4_sum_lo", 2'b00, 8'h00);
    chk_disp("t4_sum_hi", 2'b01, 8'h01);
    chk_disp("t4_status", 2'b11, 8'h00);

    // T5: reset asserted while ack is high.
    do_reset();
    x.sum = 16'h0077; x.cnt = 8'h01; x.st = 8'h02;
    sb_q.push_back(x);
    data = 16'h0077;
    req  = 1'b1;
    wait_ack(1'b1, n);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_ack_async", {31'd0, io_out[17]}, 32'd0);
    chk("t5_oeb_in_rst", {4'd0, io_oeb}, 32'h00DFFFF);
    chk_disp("t5_disp0", 2'b00, 8'h00);
    chk_disp("t5_disp1", 2'b01, 8'h00);
    chk_disp("t5_disp2", 2'b10, 8'h00);
    chk_disp("t5_disp3", 2'b11, 8'h00);
    sel = 2'b00;
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(16'h00AA, 16'h00AA, 8'h01, 8'h02);
    chk_disp("t5_sum_lo", 2'b00, 8'hAA);
    chk_disp("t5_count", 2'b10, 8'h01);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
